// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC processing element.
// Holds parameter defaults, control-word bit positions and the
// saturation helper used when a flushed accumulator is drained.
package systolic_pkg;

  localparam int LANE_W_DEF = 4;
  localparam int BEATS_DEF  = 4;
  localparam int ACC_W_DEF  = 40;

  // Working widths of the saturation helper; ACC_W must not exceed
  // SAT_IN_W and WORD_W must not exceed SAT_OUT_W.
  localparam int SAT_IN_W  = 128;
  localparam int SAT_OUT_W = 64;

  // Beat 0 is the MSB, so the first control beat lands in the top bit.
  function automatic int ctrl_valid_idx(input int beats);
    return beats - 1;
  endfunction

  // Second control beat: FLUSH on the column lane, DRAIN on the row lane.
  function automatic int ctrl_aux_idx(input int beats);
    return beats - 2;
  endfunction

  // Clamp a signed value into the signed range of a word_w-bit word.
  // The result is returned in the low word_w bits.
  function automatic logic [SAT_OUT_W-1:0] sat_word(
    input logic signed [SAT_IN_W-1:0] value,
    input int                         word_w
  );
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (SAT_IN_W'(1) <<< (word_w - 1)) - SAT_IN_W'(1);
    lo = ~hi;
    if (value > hi) begin
      sat_word = hi[SAT_OUT_W-1:0];
    end else if (value < lo) begin
      sat_word = lo[SAT_OUT_W-1:0];
    end else begin
      sat_word = value[SAT_OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/systolic_lane_serdes.sv
// One serial lane of the systolic cell.
// Collects beats 0..BEATS-2 into an in-buffer, presents the full word
// (buffer plus live beat) during the boundary cycle, and replays a
// loaded word MSB-beat first through an output shift register.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ena        0 freezes buffer and shift register
//   boundary   high in the last beat of a block
//   din        incoming beat
//   load_val   word loaded into the shift register on the boundary edge
//   word       assembled incoming word, valid while boundary is high
//   dout       outgoing beat (top LANE_W bits of the shift register)
module systolic_lane_serdes #(
  parameter int LANE_W = 4,
  parameter int BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     boundary,
  input  logic [LANE_W-1:0]        din,
  input  logic [LANE_W*BEATS-1:0]  load_val,
  output logic [LANE_W*BEATS-1:0]  word,
  output logic [LANE_W-1:0]        dout
);

  localparam int WORD_W = LANE_W * BEATS;
  localparam int BUF_W  = LANE_W * (BEATS - 1);

  logic [BUF_W-1:0]  in_buf;
  logic [WORD_W-1:0] out_sr;

  assign word = {in_buf, din};
  assign dout = out_sr[WORD_W-1 -: LANE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_buf <= '0;
      out_sr <= '0;
    end else if (ena) begin
      if (boundary) begin
        out_sr <= load_val;
      end else begin
        // Oldest beat falls off the top; after BEATS-1 beats the buffer
        // holds beats 0..BEATS-2 in MSB-first order.
        in_buf <= BUF_W'({in_buf, din});
        out_sr <= {out_sr[WORD_W-LANE_W-1:0], {LANE_W{1'b0}}};
      end
    end
  end

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC cell.
// Forwards row and column lanes with a BEATS-cycle latency, accumulates
// signed row x column products, and on a column FLUSH drains the
// saturated result onto the row lane in the first idle row slot.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ena                       0 freezes all state and outputs
//   row_in, row_ctrl_in       incoming row data / control beat
//   col_in, col_ctrl_in       incoming column data / control beat
//   row_out, row_ctrl_out     outgoing row beat (forwarded or drain)
//   col_out, col_ctrl_out     outgoing column beat (forwarded)
//   drain_ovf                 sticky, a drain result was discarded
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int BEATS  = BEATS_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [LANE_W-1:0] row_in,
  input  logic              row_ctrl_in,
  input  logic [LANE_W-1:0] col_in,
  input  logic              col_ctrl_in,
  output logic [LANE_W-1:0] row_out,
  output logic              row_ctrl_out,
  output logic [LANE_W-1:0] col_out,
  output logic              col_ctrl_out,
  output logic              drain_ovf
);

  localparam int WORD_W    = LANE_W * BEATS;
  localparam int CNT_W     = $clog2(BEATS);
  localparam int VALID_IDX = ctrl_valid_idx(BEATS);
  localparam int AUX_IDX   = ctrl_aux_idx(BEATS);

  logic [CNT_W-1:0]         cnt;
  logic                     boundary;

  logic [WORD_W-1:0]        row_word;
  logic [WORD_W-1:0]        col_word;
  logic [BEATS-1:0]         row_ctrl_word;
  logic [BEATS-1:0]         col_ctrl_word;
  logic [WORD_W-1:0]        row_load;
  logic [BEATS-1:0]         row_ctrl_load;

  logic signed [2*WORD_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    result;
  logic signed [ACC_W-1:0]    acc;
  logic [WORD_W-1:0]          result_sat;
  logic                       pend;
  logic [WORD_W-1:0]          pend_val;
  logic                       mac_en;
  logic                       flush;
  logic                       idle;
  logic                       emit;

  assign boundary = (cnt == CNT_W'(BEATS - 1));

  systolic_lane_serdes #(.LANE_W(LANE_W), .BEATS(BEATS)) u_row (
    .clk(clk), .rst(rst), .ena(ena), .boundary(boundary),
    .din(row_in), .load_val(row_load), .word(row_word), .dout(row_out)
  );

  systolic_lane_serdes #(.LANE_W(1), .BEATS(BEATS)) u_row_ctrl (
    .clk(clk), .rst(rst), .ena(ena), .boundary(boundary),
    .din(row_ctrl_in), .load_val(row_ctrl_load), .word(row_ctrl_word),
    .dout(row_ctrl_out)
  );

  // Column lane is a pure passthrough: the assembled word is reloaded as-is.
  systolic_lane_serdes #(.LANE_W(LANE_W), .BEATS(BEATS)) u_col (
    .clk(clk), .rst(rst), .ena(ena), .boundary(boundary),
    .din(col_in), .load_val(col_word), .word(col_word), .dout(col_out)
  );

  systolic_lane_serdes #(.LANE_W(1), .BEATS(BEATS)) u_col_ctrl (
    .clk(clk), .rst(rst), .ena(ena), .boundary(boundary),
    .din(col_ctrl_in), .load_val(col_ctrl_word), .word(col_ctrl_word),
    .dout(col_ctrl_out)
  );

  always_comb begin
    prod       = (2*WORD_W)'($signed(row_word)) * (2*WORD_W)'($signed(col_word));
    prod_ext   = ACC_W'(prod);
    mac_en     = row_ctrl_word[VALID_IDX] & col_ctrl_word[VALID_IDX];
    result     = acc + (mac_en ? prod_ext : '0);
    result_sat = WORD_W'(sat_word(SAT_IN_W'(result), WORD_W));

    flush = col_ctrl_word[AUX_IDX];
    idle  = !row_ctrl_word[VALID_IDX] && !row_ctrl_word[AUX_IDX];
    // A result flushed in this block may use this block's idle slot.
    emit  = idle && (pend || flush);

    row_load      = row_word;
    row_ctrl_load = row_ctrl_word;
    if (emit) begin
      row_load               = pend ? pend_val : result_sat;
      row_ctrl_load          = '0;
      row_ctrl_load[AUX_IDX] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      pend_val  <= '0;
      drain_ovf <= 1'b0;
    end else if (ena) begin
      cnt <= boundary ? '0 : cnt + 1'b1;
      if (boundary) begin
        acc <= flush ? '0 : result;
        if (flush) begin
          if (!pend) begin
            if (!emit) begin
              pend     <= 1'b1;
              pend_val <= result_sat;
            end
          end else if (emit) begin
            // Old value leaves this boundary; the new one takes its place.
            pend_val <= result_sat;
          end else begin
            drain_ovf <= 1'b1;
          end
        end else if (emit) begin
          pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
- Parametrised successor of the nibble-serial systolic passthrough cell. Row and column lanes carry WORD_W-bit words, serialised as BEATS beats of LANE_W bits each, with a 1-bit control lane per direction.
- The cell forwards both lanes with a fixed BEATS-cycle latency, as before. New: it accumulates signed row×column products and drains the result onto the row lane. Drains are arbitrated against traffic from upstream cells.
- Tiles into an output-stationary matrix-multiply array.

Parameters:
- LANE_W, 4, bits per beat on each data lane.
- BEATS, 4, beats per word (≥2). WORD_W = LANE_W*BEATS.
- ACC_W, 40, signed accumulator width (≥ 2*WORD_W).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  0 = freeze all state (count, buffers, accumulator, outputs).
- row_in  in  LANE_W  row data beat.
- row_ctrl_in  in  1  row control beat.
- col_in  in  LANE_W  column data beat.
- col_ctrl_in  in  1  column control beat.
- row_out  out  LANE_W  row data beat, registered.
- row_ctrl_out  out  1  row control beat, registered.
- col_out  out  LANE_W  column data beat, registered.
- col_ctrl_out  out  1  column control beat, registered.
- drain_ovf  out  1  sticky: a drain result was lost.

Behaviour:
- Beat counter cnt runs 0..BEATS-1, then wraps, advancing when ena=1. A block is the BEATS cycles of one count sweep. The boundary is the cycle with cnt==BEATS-1.
- Serial order: beat 0 carries the MSB nibble (bits WORD_W-1 down to WORD_W-LANE_W). The control word is assembled the same way: beat 0 becomes bit BEATS-1.
- Control bits: VALID = bit BEATS-1 on both lanes. AUX = bit BEATS-2: FLUSH on the column lane, DRAIN on the row lane.
- Deserialise: during beats 0..BEATS-2, beats are captured into in-buffers. The full word is formed at the boundary from the buffers plus the live input.
- Reserialise: on the boundary edge each lane's out shift register loads a word. On other edges it shifts by LANE_W. Outputs are the top LANE_W bits.
- Latency: beat k of incoming block N appears at output beat k of block N+1, exactly BEATS cycles later.
- Column lane: forwarded unchanged, data and control.
- MAC at boundary: if row VALID and col VALID, p = signed(row_word) × signed(col_word), sign-extended to ACC_W; otherwise p = 0.
- No FLUSH: acc <= acc + p (two's-complement wrap at ACC_W).
- FLUSH: result r = acc + p; acc <= 0. r is saturated to a signed WORD_W value and placed in the drain slot.
- Drain slot: the cell holds at most one pending result (pend flag plus value).
- Substitution: the outgoing row block N+1 carries data = pending value and ctrl = DRAIN only (VALID=0, other bits 0). This happens only when incoming row block N has VALID=0 and DRAIN=0 (an idle slot). Otherwise the incoming row word and control are forwarded and pend is held.
- A result created in block N is eligible for slot N itself. Same-boundary create-and-emit is required.
- If pend is already set, not emitted this boundary, and a new FLUSH occurs: the new result is discarded, drain_ovf <= 1 (sticky until rst), and the old pending value is kept.
- Reset (any cycle, including mid-block): cnt, in-buffers, out shift registers, acc, pend, drain_ovf and all outputs go to 0. The first post-reset block starts at cnt=0 on the following cycle.
- ena=0 on a cycle: no state changes; outputs hold.

Decomposition:
- Package systolic_pkg: parameter defaults, CTRL_VALID/CTRL_AUX bit-index functions of BEATS, and a saturate-to-WORD_W function.
- Sub-module systolic_lane_serdes (LANE_W, BEATS), instantiated four times. It contains the in-buffer, the boundary full-word output, and the out shift register with a load-value input.
- The top level holds cnt, the MAC, the drain arbitration and drain_ovf.

Test Plan:
- Passthrough: row beats 1,2,3,4 with ctrl 0,0,0,0, then idle. Expect row_out 1,2,3,4 exactly 4 cycles later. Check the column lane likewise.
- MAC+drain: block 0 row 0x0003, col 0xFFFE, both VALID (ctrl 1,0,0,0). Block 1 col ctrl 0,1,0,0 (FLUSH), row idle. Expect the block-2 row output to be 0xFFFA with ctrl 0,1,0,0; acc = 0 afterwards.
- Saturation: four VALID blocks of 0x7FFF×0x7FFF, then FLUSH. Expect the drained value 0x7FFF.
- Arbitration: FLUSH while the incoming row is VALID. Expect the row word forwarded and the drain emitted in the first later idle slot. A second FLUSH before emission gives drain_ovf=1 and only the first value drained.
- Reset mid-block: assert rst at cnt=2 with a nonzero acc. Expect all outputs 0 the next cycle; a subsequent FLUSH drains 0.
- ena low for 3 cycles mid-block: outputs hold. The stream resumes shifted by exactly 3 cycles with identical data.
